acc_ctrl_seq: RTL and testbench
===============================

Name: acc_ctrl_seq

Overview:
Parametrised multicycle controller for the accumulator datapath. It sequences fetch, decode and execute, and drives the PC/MAR/MDR/IR/ACC load strobes, the mux selects, the ALU op and memory write. It owns an iterative divider that uses a start/done handshake. It adds AND/OR, HALT, illegal-opcode trapping and divide-by-zero detection.

Parameters:
DW, 16, datapath width of ACC/MDR and divider operands
OPW, 8, opcode width; only the low 4 bits are decoded, upper bits must be 0 or the opcode is illegal

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
opcode  in  OPW  IR opcode field
zflag  in  1  ACC==0 flag from datapath
acc_in  in  DW  ACC value (dividend)
mdr_in  in  DW  MDR value (divisor)
muxPC  out  1  0=PC+1, 1=jump target
muxMAR  out  1  0=PC, 1=IR address
muxACC  out  2  0=ALU, 1=MDR, 2=quotient
loadPC, loadMAR, loadMDR, loadIR, loadACC  out  1 each  register load strobes
MemRW  out  1  1=write ACC to memory
opALU  out  3  0=pass, 1=add, 2=mul, 3=sub, 4=xor, 5=and, 6=or
quot  out  DW  divider quotient
halted  out  1  core stopped
illegal  out  1  sticky; an illegal opcode was decoded
divz  out  1  sticky; a divide by zero occurred

Behaviour:
- Package enum states: FETCH1, FETCH2, FETCH3, DECODE, ALU_RD, ALU_WB, MUL_RD, MUL_WB, DIV_RD, DIV_START, DIV_WAIT, DIV_WB, LOAD_RD, LOAD_WB, STORE, JUMP, HALT, TRAP.
- Reset:
  - state=FETCH1; halted=illegal=divz=0; divider aborted and quot=0.
  - All outputs are Moore-decoded from state.
  - rst has priority over every event, including mid-DIV_WAIT and HALT.
- Fetch:
  - FETCH1: loadMAR=1, loadPC=1, muxMAR=0, muxPC=0.
  - FETCH2: loadMDR=1.
  - FETCH3: loadIR=1.
  - DECODE: loadMAR=1, muxMAR=1.
- Decode transitions:
  - 0x0 NOP -> FETCH1.
  - 0x1/0x2/0x5/0xA/0xB -> ALU_RD.
  - 0x3 -> MUL_RD.
  - 0x4 -> DIV_RD.
  - 0x6 -> JUMP.
  - 0x7 -> JUMP if zflag else FETCH1.
  - 0x8 -> STORE.
  - 0x9 -> LOAD_RD.
  - 0xF -> HALT.
  - Any other value -> TRAP.
- Execute states:
  - ALU_RD, MUL_RD, LOAD_RD, DIV_RD: loadMDR=1.
  - ALU_WB: loadACC=1, muxACC=0, opALU per opcode.
  - MUL_WB: loadACC=1, opALU=2.
  - LOAD_WB: loadACC=1, muxACC=1.
  - STORE: MemRW=1.
  - JUMP: loadPC=1, muxPC=1.
  - All of these return to FETCH1.
- Outputs not listed for a state are 0. opALU is 0 except in ALU_WB and MUL_WB. No latches.
- Divide:
  - DIV_START: if mdr_in==0, set divz and go to FETCH1 with ACC unchanged. Otherwise pulse div_start for one cycle and go to DIV_WAIT.
  - DIV_WAIT: hold until div_done, which occurs exactly DW cycles after start. Then go to DIV_WB.
  - DIV_WB: loadACC=1, muxACC=2, then FETCH1.
  - Unsigned: quotient is floor(acc_in/mdr_in).
- Latency in cycles: NOP 4; ALU/MUL/LOAD 6; STORE/JUMP 5; JUMPZ not taken 4; DIV DW+7 (23 at default); divide-by-zero 6.
- HALT: halted=1 and all strobes 0. Held until rst.
- TRAP: sets illegal for one cycle in-state, then FETCH1. The instruction is skipped and execution continues.
- illegal and divz stay set until rst.

Optional Feature:
- Macro ACC_CTRL_MOD_EN.
- When defined:
  - Opcode 0xC (MOD) follows the DIV path.
  - DIV_WB loads the remainder through muxACC=3.
  - MOD by zero sets divz.
- When undefined:
  - 0xC traps as illegal.
  - muxACC never takes the value 3.

Decomposition:
- Package acc_ctrl_pkg holds:
  - state enum;
  - opcode localparams (OP_NOP..OP_HALT, OP_MOD);
  - muxACC select constants;
  - opALU encodings.
- Sub-module seq_divider #(DW):
  - restoring, one bit per cycle;
  - ports clk, rst, start, dividend, divisor, quot, rem, done;
  - done is a one-cycle pulse;
  - start while busy restarts the division.

Test Plan:
- ADD: opcode 0x01, ACC=5, MDR=7 -> loadACC in cycle 6 with opALU=1, back in FETCH1 at cycle 7.
- DIV: ACC=100, MDR=7, DW=16 -> quot=14, loadACC with muxACC=2 in cycle 23; divz=0.
- Divide by zero: MDR=0 -> divz=1, no loadACC, next FETCH1 after 6 cycles; divz persists over the following ADD.
- JUMPZ: zflag=0 -> no loadPC beyond fetch and 4-cycle instruction. zflag=1 -> JUMP state with muxPC=1, loadPC=1.
- Illegal and HALT:
  - opcode 0x0D -> illegal=1, execution continues.
  - opcode 0x1F (upper bit set) -> illegal.
  - opcode 0x0F -> halted=1, all strobes 0 for 20 cycles.
- Reset mid-divide: rst asserted in DIV_WAIT cycle 5 -> next cycle in FETCH1, flags 0, no loadACC, a subsequent DIV gives the correct result. With ACC_CTRL_MOD_EN, MOD 100,7 -> ACC loaded with muxACC=3 and rem=2.

Source files
------------

// File: rtl/acc_ctrl_pkg.sv
// Shared types and encodings for the accumulator-machine controller.
// ACC_CTRL_MOD_EN (optional) adds the MOD opcode, steering the remainder into ACC.
package acc_ctrl_pkg;

  localparam int unsigned OPC_W = 4;

  typedef enum logic [4:0] {
    FETCH1, FETCH2, FETCH3, DECODE,
    ALU_RD, ALU_WB, MUL_RD, MUL_WB,
    DIV_RD, DIV_START, DIV_WAIT, DIV_WB,
    LOAD_RD, LOAD_WB, STORE, JUMP,
    HALT, TRAP
  } state_t;

  localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'h2;
  localparam logic [OPC_W-1:0] OP_MUL   = 4'h3;
  localparam logic [OPC_W-1:0] OP_DIV   = 4'h4;
  localparam logic [OPC_W-1:0] OP_XOR   = 4'h5;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'h6;
  localparam logic [OPC_W-1:0] OP_JZ    = 4'h7;
  localparam logic [OPC_W-1:0] OP_STORE = 4'h8;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'h9;
  localparam logic [OPC_W-1:0] OP_AND   = 4'hA;
  localparam logic [OPC_W-1:0] OP_OR    = 4'hB;
  localparam logic [OPC_W-1:0] OP_MOD   = 4'hC;
  localparam logic [OPC_W-1:0] OP_HALT  = 4'hF;

  localparam logic [1:0] ACC_SEL_ALU  = 2'd0;
  localparam logic [1:0] ACC_SEL_MDR  = 2'd1;
  localparam logic [1:0] ACC_SEL_QUOT = 2'd2;
  localparam logic [1:0] ACC_SEL_REM  = 2'd3;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_MUL  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_AND  = 3'd5;
  localparam logic [2:0] ALU_OR   = 3'd6;

  typedef struct packed {
    logic       mux_pc;
    logic       mux_mar;
    logic [1:0] mux_acc;
    logic       load_pc;
    logic       load_mar;
    logic       load_mdr;
    logic       load_ir;
    logic       load_acc;
    logic       mem_rw;
    logic [2:0] op_alu;
  } ctrl_t;

  function automatic logic [2:0] alu_op(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_XOR:  return ALU_XOR;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_PASS;
    endcase
  endfunction

  // Moore control word for a state; the opcode only refines ALU_WB and DIV_WB.
  function automatic ctrl_t ctrl_decode(input state_t s, input logic [OPC_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH1: begin
        c.load_mar = 1'b1;
        c.load_pc  = 1'b1;
      end
      FETCH2, ALU_RD, MUL_RD, LOAD_RD, DIV_RD: c.load_mdr = 1'b1;
      FETCH3: c.load_ir = 1'b1;
      DECODE: begin
        c.load_mar = 1'b1;
        c.mux_mar  = 1'b1;
      end
      ALU_WB: begin
        c.load_acc = 1'b1;
        c.mux_acc  = ACC_SEL_ALU;
        c.op_alu   = alu_op(op);
      end
      MUL_WB: begin
        c.load_acc = 1'b1;
        c.op_alu   = ALU_MUL;
      end
      LOAD_WB: begin
        c.load_acc = 1'b1;
        c.mux_acc  = ACC_SEL_MDR;
      end
      DIV_WB: begin
        c.load_acc = 1'b1;
`ifdef ACC_CTRL_MOD_EN
        c.mux_acc  = (op == OP_MOD) ? ACC_SEL_REM : ACC_SEL_QUOT;
`else
        c.mux_acc  = ACC_SEL_QUOT;
`endif
      end
      STORE: c.mem_rw = 1'b1;
      JUMP: begin
        c.load_pc = 1'b1;
        c.mux_pc  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/acc_ctrl_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses DW cycles after start.
module seq_divider #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] quot,
  output logic [DW-1:0] rem,
  output logic          done
);

  localparam int unsigned CW = $clog2(DW + 1);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [DW-1:0] part;
  logic [DW-1:0] shq;
  logic [DW-1:0] dvs;

  logic [DW-1:0] src_part_c;
  logic [DW-1:0] src_q_c;
  logic [DW-1:0] src_d_c;
  logic [DW:0]   shifted_c;
  logic [DW:0]   trial_c;
  logic [DW-1:0] step_part_c;
  logic [DW-1:0] step_q_c;

  // The start cycle already resolves the first quotient bit from the raw operands.
  always_comb begin
    src_part_c  = start ? '0 : part;
    src_q_c     = start ? dividend : shq;
    src_d_c     = start ? divisor : dvs;
    shifted_c   = {src_part_c, src_q_c[DW-1]};
    trial_c     = shifted_c - {1'b0, src_d_c};
    step_part_c = trial_c[DW] ? shifted_c[DW-1:0] : trial_c[DW-1:0];
    step_q_c    = {src_q_c[DW-2:0], ~trial_c[DW]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      part <= '0;
      shq  <= '0;
      dvs  <= '0;
      quot <= '0;
      rem  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        part <= step_part_c;
        shq  <= step_q_c;
        dvs  <= divisor;
        cnt  <= CW'(DW - 1);
        busy <= 1'b1;
      end else if (busy) begin
        part <= step_part_c;
        shq  <= step_q_c;
        cnt  <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          quot <= step_q_c;
          rem  <= step_part_c;
        end
      end
    end
  end

endmodule

// File: rtl/acc_ctrl_seq.sv
// Multicycle fetch/decode/execute controller for the accumulator datapath with iterative divide.
// Optional ACC_CTRL_MOD_EN enables opcode 0xC (MOD) through the divide path.
module acc_ctrl_seq
  import acc_ctrl_pkg::*;
#(
  parameter int unsigned DW  = 16,
  parameter int unsigned OPW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zflag,
  input  logic [DW-1:0]  acc_in,
  input  logic [DW-1:0]  mdr_in,
  output logic           muxPC,
  output logic           muxMAR,
  output logic [1:0]     muxACC,
  output logic           loadPC,
  output logic           loadMAR,
  output logic           loadMDR,
  output logic           loadIR,
  output logic           loadACC,
  output logic           MemRW,
  output logic [2:0]     opALU,
  output logic [DW-1:0]  quot,
  output logic           halted,
  output logic           illegal,
  output logic           divz
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;
  ctrl_t  ctrl_next;

  logic [OPC_W-1:0] op_c;
  logic             op_legal_c;
  logic             div_start_c;
  logic             div_zero_c;
  logic             div_done;
  logic [DW-1:0]    div_rem_unused;

  assign op_c        = opcode[OPC_W-1:0];
  assign op_legal_c  = ((opcode >> OPC_W) == '0);
  assign div_start_c = (state == DIV_START) && (mdr_in != '0);
  assign div_zero_c  = (state == DIV_START) && (mdr_in == '0);

  // The remainder is only consumed by the datapath's own mux, not at this boundary.
  seq_divider #(.DW(DW)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_c),
    .dividend (acc_in),
    .divisor  (mdr_in),
    .quot     (quot),
    .rem      (div_rem_unused),
    .done     (div_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH1;
    else     state <= state_next;
  end

  // Next state, plus the control word of that state so the strobes register in step with it.
  always_comb begin
    state_next = state;
    ctrl_next  = '0;
    case (state)
      FETCH1: state_next = FETCH2;
      FETCH2: state_next = FETCH3;
      FETCH3: state_next = DECODE;
      DECODE: begin
        if (!op_legal_c) begin
          state_next = TRAP;
        end else begin
          case (op_c)
            OP_NOP:                              state_next = FETCH1;
            OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR: state_next = ALU_RD;
            OP_MUL:                              state_next = MUL_RD;
            OP_DIV:                              state_next = DIV_RD;
`ifdef ACC_CTRL_MOD_EN
            OP_MOD:                              state_next = DIV_RD;
`endif
            OP_JMP:                              state_next = JUMP;
            OP_JZ:                               state_next = zflag ? JUMP : FETCH1;
            OP_STORE:                            state_next = STORE;
            OP_LOAD:                             state_next = LOAD_RD;
            OP_HALT:                             state_next = HALT;
            default:                             state_next = TRAP;
          endcase
        end
      end
      ALU_RD:    state_next = ALU_WB;
      MUL_RD:    state_next = MUL_WB;
      LOAD_RD:   state_next = LOAD_WB;
      DIV_RD:    state_next = DIV_START;
      DIV_START: state_next = (mdr_in == '0) ? FETCH1 : DIV_WAIT;
      DIV_WAIT:  state_next = div_done ? DIV_WB : DIV_WAIT;
      HALT:      state_next = HALT;
      default:   state_next = FETCH1;
    endcase
    ctrl_next = ctrl_decode(state_next, op_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl    <= ctrl_decode(FETCH1, OP_NOP);
      halted  <= 1'b0;
      illegal <= 1'b0;
      divz    <= 1'b0;
    end else begin
      ctrl    <= ctrl_next;
      halted  <= (state_next == HALT);
      illegal <= illegal | (state_next == TRAP);
      divz    <= divz | div_zero_c;
    end
  end

  assign muxPC   = ctrl.mux_pc;
  assign muxMAR  = ctrl.mux_mar;
  assign muxACC  = ctrl.mux_acc;
  assign loadPC  = ctrl.load_pc;
  assign loadMAR = ctrl.load_mar;
  assign loadMDR = ctrl.load_mdr;
  assign loadIR  = ctrl.load_ir;
  assign loadACC = ctrl.load_acc;
  assign MemRW   = ctrl.mem_rw;
  assign opALU   = ctrl.op_alu;

endmodule

// File: tb/tb_acc_ctrl_seq.sv
// Directed cycle-accurate bench for acc_ctrl_seq: strobe sequences, divide, traps, halt and reset.
module tb_acc_ctrl_seq;

  localparam int unsigned DW  = 16;
  localparam int unsigned OPW = 8;

  // Control word {muxPC, muxMAR, muxACC[1:0], loadPC, loadMAR, loadMDR, loadIR, loadACC, MemRW, opALU[2:0]}
  localparam logic [12:0] S_F1    = 13'h0180;
  localparam logic [12:0] S_RD    = 13'h0040;
  localparam logic [12:0] S_F3    = 13'h0020;
  localparam logic [12:0] S_DEC   = 13'h0880;
  localparam logic [12:0] S_IDLE  = 13'h0000;
  localparam logic [12:0] S_LDWB  = 13'h0210;
  localparam logic [12:0] S_DIVWB = 13'h0410;
  localparam logic [12:0] S_MODWB = 13'h0610;
  localparam logic [12:0] S_ST    = 13'h0008;
  localparam logic [12:0] S_JMP   = 13'h1100;

  logic           clk = 1'b0;
  logic           rst;
  logic [OPW-1:0] opcode;
  logic           zflag;
  logic [DW-1:0]  acc_in;
  logic [DW-1:0]  mdr_in;
  logic           muxPC, muxMAR, loadPC, loadMAR, loadMDR, loadIR, loadACC, MemRW;
  logic [1:0]     muxACC;
  logic [2:0]     opALU;
  logic [DW-1:0]  quot;
  logic           halted, illegal, divz;
  logic [12:0]    sig;

  int errors = 0;
  int checks = 0;

  acc_ctrl_seq #(.DW(DW), .OPW(OPW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zflag(zflag), .acc_in(acc_in), .mdr_in(mdr_in),
    .muxPC(muxPC), .muxMAR(muxMAR), .muxACC(muxACC), .loadPC(loadPC), .loadMAR(loadMAR),
    .loadMDR(loadMDR), .loadIR(loadIR), .loadACC(loadACC), .MemRW(MemRW), .opALU(opALU),
    .quot(quot), .halted(halted), .illegal(illegal), .divz(divz)
  );

  assign sig = {muxPC, muxMAR, muxACC, loadPC, loadMAR, loadMDR, loadIR, loadACC, MemRW, opALU};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    opcode = '0; zflag = 1'b0; acc_in = '0; mdr_in = '0;
    do_reset();
    checks++;
    if (sig !== S_F1) begin errors++; $display("FAIL reset_state sig=%h want=%h", sig, S_F1); end
    checks++;
    if ({halted, illegal, divz} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b want=000", {halted, illegal, divz});
    end
    checks++;
    if (quot !== 16'd0) begin errors++; $display("FAIL reset_quot got=%0d want=0", quot); end
  endtask

  task automatic test_nop();
    logic [12:0] e;
    opcode = 8'h00;
    for (int c = 1; c <= 4; c++) begin
      case (c) 1: e = S_F1; 2: e = S_RD; 3: e = S_F3; default: e = S_DEC; endcase
      checks++;
      if (sig !== e) begin errors++; $display("FAIL nop cycle%0d sig=%h want=%h", c, sig, e); end
      tick();
    end
    checks++;
    if (sig !== S_F1) begin errors++; $display("FAIL nop_return sig=%h want=%h", sig, S_F1); end
  endtask

  task automatic test_alu();
    logic [3:0]  opc [6];
    logic [12:0] wb  [6];
    logic [12:0] e;
    opc[0] = 4'h1; wb[0] = 13'h0011;
    opc[1] = 4'h2; wb[1] = 13'h0013;
    opc[2] = 4'h5; wb[2] = 13'h0014;
    opc[3] = 4'hA; wb[3] = 13'h0015;
    opc[4] = 4'hB; wb[4] = 13'h0016;
    opc[5] = 4'h3; wb[5] = 13'h0012;
    acc_in = 16'd5; mdr_in = 16'd7;
    for (int k = 0; k < 6; k++) begin
      opcode = OPW'(opc[k]);
      for (int c = 1; c <= 6; c++) begin
        case (c) 1: e = S_F1; 2: e = S_RD; 3: e = S_F3; 4: e = S_DEC; 5: e = S_RD; default: e = wb[k]; endcase
        checks++;
        if (sig !== e) begin errors++; $display("FAIL alu op=%h cycle%0d sig=%h want=%h", opc[k], c, sig, e); end
        tick();
      end
      checks++;
      if (sig !== S_F1) begin errors++; $display("FAIL alu_return op=%h sig=%h want=%h", opc[k], sig, S_F1); end
    end
  endtask

  task automatic test_mem_branch();
    logic [3:0]  opc  [5];
    logic        z    [5];
    int          len  [5];
    logic [12:0] last [5];
    logic [12:0] e;
    opc[0] = 4'h9; z[0] = 1'b0; len[0] = 6; last[0] = S_LDWB;
    opc[1] = 4'h8; z[1] = 1'b0; len[1] = 5; last[1] = S_ST;
    opc[2] = 4'h6; z[2] = 1'b0; len[2] = 5; last[2] = S_JMP;
    opc[3] = 4'h7; z[3] = 1'b0; len[3] = 4; last[3] = S_DEC;
    opc[4] = 4'h7; z[4] = 1'b1; len[4] = 5; last[4] = S_JMP;
    for (int k = 0; k < 5; k++) begin
      opcode = OPW'(opc[k]);
      zflag  = z[k];
      for (int c = 1; c <= len[k]; c++) begin
        case (c)
          1: e = S_F1; 2: e = S_RD; 3: e = S_F3; 4: e = S_DEC;
          5: e = (len[k] == 6) ? S_RD : last[k];
          default: e = last[k];
        endcase
        checks++;
        if (sig !== e) begin errors++; $display("FAIL exec op=%h z=%b cycle%0d sig=%h want=%h", opc[k], z[k], c, sig, e); end
        tick();
      end
      checks++;
      if (sig !== S_F1) begin errors++; $display("FAIL exec_return op=%h z=%b sig=%h want=%h", opc[k], z[k], sig, S_F1); end
    end
    zflag = 1'b0;
  endtask

  task automatic run_div(input logic [3:0] opc, input logic [DW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] q_want, input logic [12:0] wb_want);
    logic [12:0] e;
    opcode = OPW'(opc); acc_in = a; mdr_in = d;
    for (int c = 1; c <= 23; c++) begin
      case (c) 1: e = S_F1; 2: e = S_RD; 3: e = S_F3; 4: e = S_DEC; 5: e = S_RD; 23: e = wb_want; default: e = S_IDLE; endcase
      checks++;
      if (sig !== e) begin errors++; $display("FAIL div op=%h cycle%0d sig=%h want=%h", opc, c, sig, e); end
      if (c == 23) begin
        checks++;
        if (quot !== q_want) begin errors++; $display("FAIL div_quot %0d/%0d got=%0d want=%0d", a, d, quot, q_want); end
      end
      tick();
    end
    checks++;
    if (sig !== S_F1) begin errors++; $display("FAIL div_return sig=%h want=%h", sig, S_F1); end
  endtask

  task automatic test_div();
    run_div(4'h4, 16'd100, 16'd7, 16'd14, S_DIVWB);
    checks++;
    if (divz !== 1'b0) begin errors++; $display("FAIL div_divz got=%b want=0", divz); end
  endtask

  task automatic test_divz();
    logic [12:0] e;
    opcode = 8'h04; acc_in = 16'd55; mdr_in = 16'd0;
    for (int c = 1; c <= 6; c++) begin
      case (c) 1: e = S_F1; 2: e = S_RD; 3: e = S_F3; 4: e = S_DEC; 5: e = S_RD; default: e = S_IDLE; endcase
      checks++;
      if (sig !== e) begin errors++; $display("FAIL divz cycle%0d sig=%h want=%h", c, sig, e); end
      tick();
    end
    checks++;
    if (sig !== S_F1) begin errors++; $display("FAIL divz_return sig=%h want=%h", sig, S_F1); end
    checks++;
    if (divz !== 1'b1) begin errors++; $display("FAIL divz_flag got=%b want=1", divz); end
    opcode = 8'h01; mdr_in = 16'd7;
    for (int c = 1; c <= 6; c++) tick();
    checks++;
    if (sig !== S_F1) begin errors++; $display("FAIL divz_add_return sig=%h want=%h", sig, S_F1); end
    checks++;
    if (divz !== 1'b1) begin errors++; $display("FAIL divz_sticky got=%b want=1", divz); end
    checks++;
    if (quot !== 16'd14) begin errors++; $display("FAIL divz_quot_kept got=%0d want=14", quot); end
  endtask

  task automatic test_trap(input logic [OPW-1:0] opc);
    logic [12:0] e;
    opcode = opc;
    for (int c = 1; c <= 5; c++) begin
      case (c) 1: e = S_F1; 2: e = S_RD; 3: e = S_F3; 4: e = S_DEC; default: e = S_IDLE; endcase
      checks++;
      if (sig !== e) begin errors++; $display("FAIL trap op=%h cycle%0d sig=%h want=%h", opc, c, sig, e); end
      if (c == 5) begin
        checks++;
        if ({illegal, halted} !== 2'b10) begin
          errors++; $display("FAIL trap_flags op=%h illegal,halted=%b want=10", opc, {illegal, halted});
        end
      end
      tick();
    end
    checks++;
    if (sig !== S_F1) begin errors++; $display("FAIL trap_continue op=%h sig=%h want=%h", opc, sig, S_F1); end
  endtask

  task automatic test_reset_mid_div();
    opcode = 8'h04; acc_in = 16'd1000; mdr_in = 16'd33;
    for (int c = 1; c <= 10; c++) tick();
    checks++;
    if (sig !== S_IDLE) begin errors++; $display("FAIL middiv_wait sig=%h want=%h", sig, S_IDLE); end
    rst = 1'b1;
    tick();
    checks++;
    if (sig !== S_F1) begin errors++; $display("FAIL middiv_reset_state sig=%h want=%h", sig, S_F1); end
    checks++;
    if ({halted, illegal, divz} !== 3'b000) begin
      errors++; $display("FAIL middiv_flags got=%b want=000", {halted, illegal, divz});
    end
    checks++;
    if (quot !== 16'd0) begin errors++; $display("FAIL middiv_quot got=%0d want=0", quot); end
    rst = 1'b0;
    run_div(4'h4, 16'd1000, 16'd33, 16'd30, S_DIVWB);
  endtask

  task automatic test_opc_c();
    do_reset();
`ifdef ACC_CTRL_MOD_EN
    run_div(4'hC, 16'd100, 16'd7, 16'd14, S_MODWB);
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL mod_not_illegal got=%b want=0", illegal); end
`else
    test_trap(8'h0C);
`endif
  endtask

  task automatic test_halt();
    logic [12:0] e;
    opcode = 8'h0F;
    for (int c = 1; c <= 4; c++) begin
      case (c) 1: e = S_F1; 2: e = S_RD; 3: e = S_F3; default: e = S_DEC; endcase
      checks++;
      if (sig !== e) begin errors++; $display("FAIL halt cycle%0d sig=%h want=%h", c, sig, e); end
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      checks++;
      if ({halted, sig} !== {1'b1, S_IDLE}) begin
        errors++; $display("FAIL halt_hold n=%0d halted=%b sig=%h want=1/%h", c, halted, sig, S_IDLE);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({halted, sig} !== {1'b0, S_F1}) begin
      errors++; $display("FAIL halt_reset halted=%b sig=%h want=0/%h", halted, sig, S_F1);
    end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_alu();
    test_mem_branch();
    test_div();
    test_divz();
    test_trap(8'h0D);
    test_nop();
    test_reset_mid_div();
    do_reset();
    test_trap(8'h1F);
    test_opc_c();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
